tinycpu_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port program/data RAM (12-bit address, 16-bit data) between the tinycpu fetch/execute bus and a host loader/debug port. It lets the host preload or inspect memory while the CPU is halted or running. A registered request/grant handshake returns read data with fixed latency. Sits between tinycpu's abus/dbus memory interface and the RAM macro.

---
 rtl/tinycpu_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tinycpu_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinycpu_mem_arbiter.sv
// Two-master arbiter sharing the single-port tinycpu RAM between the CPU bus
// and the host loader/debug port; one access in flight, registered handshake.
module tinycpu_mem_arbiter #(
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic        host_lock,
  input  logic [11:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [15:0] host_rdata,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  starve_q, starve_d;
  logic        lock_q, lock_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] host_rdata_q, host_rdata_d;

  logic        lock_active;
  logic        host_wins;

  // A held lock only counts while the host is still asking for it, so dropping
  // host_lock hands the very next arbitration back to the normal rules.
  always_comb begin
    lock_active = lock_q & host_lock & host_req;
    if (lock_active) begin
      host_wins = 1'b1;
    end else if (host_req != cpu_req) begin
      host_wins = host_req;
    end else if (PRIO_MODE == 0) begin
      host_wins = ~last_q;
    end else begin
      host_wins = (starve_q >= StarveLim);
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    lock_d       = lock_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    unique case (state_q)
      IDLE: begin
        lock_d = lock_q & host_lock & host_req;
        if (cpu_req || host_req) begin
          state_d = ACCESS;
          owner_d = host_wins;
          last_d  = host_wins;
          if (host_wins) begin
            we_d     = host_we;
            addr_d   = host_addr;
            wdata_d  = host_wdata;
            starve_d = 8'd0;
            lock_d   = host_lock;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            if (host_req && (starve_q != 8'hFF)) begin
              starve_d = starve_q + 8'd1;
            end
          end
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q) begin
          host_rdata_d = mem_rdata;
        end else begin
          cpu_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_q resets to host so the CPU takes the first round-robin tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 12'd0;
      wdata_q      <= 16'd0;
      starve_q     <= 8'd0;
      lock_q       <= 1'b0;
      cpu_rdata_q  <= 16'd0;
      host_rdata_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      lock_q       <= lock_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign cpu_gnt     = (state_q == ACCESS) & ~owner_q;
  assign host_gnt    = (state_q == ACCESS) & owner_q;
  assign mem_we      = (state_q == ACCESS) & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign cpu_rvalid  = (state_q == RESP) & ~owner_q;
  assign host_rvalid = (state_q == RESP) & owner_q;
  // The RAM's read data is live during RESP; the holding registers take over after.
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tinycpu_mem_arbiter.sv
// Bench for tinycpu_mem_arbiter: one round-robin and one CPU-priority instance
// share the same stimulus; each has its own RAM model and grant/read scoreboard.
module tb_tinycpu_mem_arbiter;

  localparam int STARVE = 3;

  typedef struct {
    bit          host;
    bit          we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRdata;
  } vecT;

  typedef struct {
    bit          host;
    bit          we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          gcyc;
  } expT;

  typedef struct {
    bit          host;
    logic [15:0] data;
    int          rcyc;
  } rdT;

  logic        clk;
  logic        reset;
  logic        cpuReq, cpuWe, hostReq, hostWe, hostLock;
  logic [11:0] cpuAddr, hostAddr;
  logic [15:0] cpuWdata, hostWdata;

  logic        dCpuGnt [2];
  logic        dCpuRvalid [2];
  logic [15:0] dCpuRdata [2];
  logic        dHostGnt [2];
  logic        dHostRvalid [2];
  logic [15:0] dHostRdata [2];
  logic        dMemWe [2];
  logic [11:0] dMemAddr [2];
  logic [15:0] dMemWdata [2];
  logic [15:0] memRdata [2];
  logic        dOwner [2];
  logic        dBusy [2];

  logic [15:0] ram0 [4096];
  logic [15:0] ram1 [4096];

  expT gq [2][$];
  rdT  rq [2][$];
  vecT vecs [10];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  tinycpu_mem_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(8)) dutRr (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_gnt(dCpuGnt[0]), .cpu_rvalid(dCpuRvalid[0]), .cpu_rdata(dCpuRdata[0]),
    .host_req(hostReq), .host_we(hostWe), .host_lock(hostLock),
    .host_addr(hostAddr), .host_wdata(hostWdata),
    .host_gnt(dHostGnt[0]), .host_rvalid(dHostRvalid[0]), .host_rdata(dHostRdata[0]),
    .mem_we(dMemWe[0]), .mem_addr(dMemAddr[0]), .mem_wdata(dMemWdata[0]),
    .mem_rdata(memRdata[0]), .owner(dOwner[0]), .busy(dBusy[0])
  );

  tinycpu_mem_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(STARVE)) dutPrio (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_gnt(dCpuGnt[1]), .cpu_rvalid(dCpuRvalid[1]), .cpu_rdata(dCpuRdata[1]),
    .host_req(hostReq), .host_we(hostWe), .host_lock(hostLock),
    .host_addr(hostAddr), .host_wdata(hostWdata),
    .host_gnt(dHostGnt[1]), .host_rvalid(dHostRvalid[1]), .host_rdata(dHostRdata[1]),
    .mem_we(dMemWe[1]), .mem_addr(dMemAddr[1]), .mem_wdata(dMemWdata[1]),
    .mem_rdata(memRdata[1]), .owner(dOwner[1]), .busy(dBusy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram0[i] = 16'd0;
      ram1[i] = 16'd0;
    end
    memRdata[0] = 16'd0;
    memRdata[1] = 16'd0;
  end

  // Synchronous-read RAM models, one per instance.
  always @(posedge clk) begin
    if (dMemWe[0]) ram0[dMemAddr[0]] <= dMemWdata[0];
    memRdata[0] <= ram0[dMemAddr[0]];
    if (dMemWe[1]) ram1[dMemAddr[1]] <= dMemWdata[1];
    memRdata[1] <= ram1[dMemAddr[1]];
  end

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic expectGrant(input int d, input bit host, input bit we,
                             input logic [11:0] addr, input logic [15:0] wdata,
                             input logic [15:0] rdata, input int gcyc);
    gq[d].push_back('{host, we, addr, wdata, rdata, gcyc});
  endtask

  // Grants and read responses are popped from the scoreboard as they appear.
  always @(negedge clk) begin
    expT e;
    rdT  r;
    if (!reset) begin
      rq[0].delete();
      rq[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (dCpuGnt[d] || dHostGnt[d]) begin
          checkOutput("double_grant", d, 32'(dCpuGnt[d] & dHostGnt[d]), 0);
          checkOutput("gnt_expected", d, 32'(gq[d].size() != 0), 1);
          if (gq[d].size() != 0) begin
            e = gq[d].pop_front();
            checkOutput("gnt_master", d, 32'(dHostGnt[d]), 32'(e.host));
            checkOutput("gnt_cycle", d, cyc, e.gcyc);
            checkOutput("mem_we", d, 32'(dMemWe[d]), 32'(e.we));
            checkOutput("mem_addr", d, 32'(dMemAddr[d]), 32'(e.addr));
            if (e.we) checkOutput("mem_wdata", d, 32'(dMemWdata[d]), 32'(e.wdata));
            checkOutput("owner", d, 32'(dOwner[d]), 32'(e.host));
            checkOutput("busy_access", d, 32'(dBusy[d]), 1);
            if (!e.we) rq[d].push_back('{e.host, e.rdata, cyc + 1});
          end
        end
        if (dCpuRvalid[d] || dHostRvalid[d]) begin
          checkOutput("double_rvalid", d, 32'(dCpuRvalid[d] & dHostRvalid[d]), 0);
          checkOutput("rvalid_expected", d, 32'(rq[d].size() != 0), 1);
          if (rq[d].size() != 0) begin
            r = rq[d].pop_front();
            checkOutput("rvalid_master", d, 32'(dHostRvalid[d]), 32'(r.host));
            checkOutput("rvalid_cycle", d, cyc, r.rcyc);
            checkOutput("rdata", d, 32'(r.host ? dHostRdata[d] : dCpuRdata[d]), 32'(r.data));
            checkOutput("busy_resp", d, 32'(dBusy[d]), 1);
          end
        end
      end
    end
  end

  task automatic checkResetOutputs();
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_cpu_gnt", d, 32'(dCpuGnt[d]), 0);
      checkOutput("rst_host_gnt", d, 32'(dHostGnt[d]), 0);
      checkOutput("rst_cpu_rvalid", d, 32'(dCpuRvalid[d]), 0);
      checkOutput("rst_host_rvalid", d, 32'(dHostRvalid[d]), 0);
      checkOutput("rst_mem_we", d, 32'(dMemWe[d]), 0);
      checkOutput("rst_busy", d, 32'(dBusy[d]), 0);
      checkOutput("rst_owner", d, 32'(dOwner[d]), 0);
      checkOutput("rst_mem_addr", d, 32'(dMemAddr[d]), 0);
      checkOutput("rst_mem_wdata", d, 32'(dMemWdata[d]), 0);
      checkOutput("rst_cpu_rdata", d, 32'(dCpuRdata[d]), 0);
      checkOutput("rst_host_rdata", d, 32'(dHostRdata[d]), 0);
    end
  endtask

  // Single-requester access: request raised in cycle k, grant due in k+1.
  task automatic applyStimulus(input vecT v);
    @(posedge clk); #1;
    if (v.host) begin
      hostReq = 1'b1; hostWe = v.we; hostAddr = v.addr; hostWdata = v.wdata;
    end else begin
      cpuReq = 1'b1; cpuWe = v.we; cpuAddr = v.addr; cpuWdata = v.wdata;
    end
    for (int d = 0; d < 2; d++) expectGrant(d, v.host, v.we, v.addr, v.wdata, v.expRdata, cyc + 1);
    repeat (2) @(posedge clk);
    #1;
    cpuReq  = 1'b0;
    hostReq = 1'b0;
    @(posedge clk);
  endtask

  task automatic drainQueues(input string tag);
    int n = 0;
    while ((gq[0].size() + gq[1].size() + rq[0].size() + rq[1].size()) != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    for (int d = 0; d < 2; d++) begin
      checkOutput({tag, "_gnt_pending"}, d, gq[d].size(), 0);
      checkOutput({tag, "_rd_pending"}, d, rq[d].size(), 0);
      gq[d].delete();
      rq[d].delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{1'b1, 1'b1, 12'h010, 16'h1234, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'h1234};
    vecs[2] = '{1'b0, 1'b1, 12'h020, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 12'h020, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 12'h010, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 12'hFFF, 16'hA5A5, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 12'h000, 16'h5A5A, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hA5A5};
    vecs[8] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'h5A5A};
    vecs[9] = '{1'b1, 1'b0, 12'h020, 16'h0000, 16'hBEEF};

    reset = 1'b0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 12'd0; cpuWdata = 16'd0;
    hostReq = 1'b0; hostWe = 1'b0; hostLock = 1'b0; hostAddr = 12'd0; hostWdata = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    reset = 1'b1;

    $display("[TB] single-master table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    drainQueues("table");
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("cpu_rdata_hold", d, 32'(dCpuRdata[d]), 32'(vecs[8].expRdata));
      checkOutput("host_rdata_hold", d, 32'(dHostRdata[d]), 32'(vecs[9].expRdata));
    end

    $display("[TB] tie with both reads held");
    @(posedge clk); #1;
    k = cyc;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h020;
    hostReq = 1'b1; hostWe = 1'b0; hostAddr = 12'h010;
    for (int i = 0; i < 5; i++) begin
      expectGrant(0, (i % 2) == 1, 1'b0, (i % 2) == 1 ? 12'h010 : 12'h020, 16'h0,
                  (i % 2) == 1 ? 16'h1234 : 16'hBEEF, k + 1 + 3 * i);
      expectGrant(1, i == STARVE, 1'b0, (i == STARVE) ? 12'h010 : 12'h020, 16'h0,
                  (i == STARVE) ? 16'h1234 : 16'hBEEF, k + 1 + 3 * i);
    end
    repeat (14) @(posedge clk);
    #1;
    cpuReq = 1'b0; hostReq = 1'b0;
    drainQueues("tie");

    $display("[TB] host lock");
    @(posedge clk); #1;
    k = cyc;
    hostReq = 1'b1; hostWe = 1'b1; hostLock = 1'b1; hostAddr = 12'h100; hostWdata = 16'hC0DE;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) expectGrant(d, 1'b1, 1'b1, 12'h100, 16'hC0DE, 16'h0, k + 1 + 2 * i);
      expectGrant(d, 1'b0, 1'b1, 12'h200, 16'h7777, 16'h0, k + 9);
    end
    @(posedge clk); #1;
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 12'h200; cpuWdata = 16'h7777;
    repeat (6) @(posedge clk);
    #1;
    hostLock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpuReq = 1'b0; hostReq = 1'b0;
    drainQueues("lock");

    $display("[TB] cpu request during host access");
    @(posedge clk); #1;
    k = cyc;
    hostReq = 1'b1; hostWe = 1'b0; hostAddr = 12'h010;
    for (int d = 0; d < 2; d++) begin
      expectGrant(d, 1'b1, 1'b0, 12'h010, 16'h0, 16'h1234, k + 1);
      expectGrant(d, 1'b0, 1'b0, 12'h020, 16'h0, 16'hBEEF, k + 4);
    end
    @(posedge clk); #1;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h020;
    @(posedge clk); #1;
    hostReq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpuReq = 1'b0;
    drainQueues("late");

    $display("[TB] reset during cpu read response");
    @(posedge clk); #1;
    k = cyc;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h020;
    for (int d = 0; d < 2; d++) expectGrant(d, 1'b0, 1'b0, 12'h020, 16'h0, 16'hBEEF, k + 1);
    @(posedge clk); #1;
    cpuReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkResetOutputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h020;
    hostReq = 1'b1; hostWe = 1'b0; hostAddr = 12'h010;
    for (int d = 0; d < 2; d++) expectGrant(d, 1'b0, 1'b0, 12'h020, 16'h0, 16'hBEEF, k + 1);
    repeat (2) @(posedge clk);
    #1;
    cpuReq = 1'b0; hostReq = 1'b0;
    drainQueues("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
